// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: MIPS funct codes,
// FSM state encodings and the operation selector.
package mult_div_unit_pkg;

  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1a;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_RUN  = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;
  localparam logic [1:0] MD_DONE = 2'd3;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_t;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// The remainder is always below the divisor, so its input needs only WIDTH bits.
module mult_div_unit_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {rem, quo[WIDTH-1]};
  // Extra MSB of diff acts as the borrow: set means the trial subtract failed.
  assign diff     = {1'b0, shifted} - {1'b0, divisor};
  assign rem_next = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
  assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH+1]};

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit.
// acc/q/mcand are shared: Booth uses {acc,q,q_m1}, divide uses acc=rem, q=quo, mcand=divisor.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  logic [1:0]       state;
  md_op_t           op;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH:0]   mcand;
  logic             sign_q;
  logic             sign_r;
  logic             dz;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  // -2^(W-1) negates to itself, which is its correct unsigned magnitude.
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  always_comb begin
    booth_sum = acc;
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
  end

  mult_div_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc[WIDTH-1:0]),
    .quo      (q),
    .divisor  (mcand),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= MD_IDLE;
      op        <= OP_MUL;
      cnt       <= '0;
      acc       <= '0;
      q         <= '0;
      q_m1      <= 1'b0;
      mcand     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      dz        <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start_mult) begin
            op    <= OP_MUL;
            acc   <= '0;
            q     <= b;
            q_m1  <= 1'b0;
            mcand <= {a[WIDTH-1], a};
            cnt   <= CNT_W'(WIDTH);
            state <= MD_RUN;
          end else if (start_div) begin
            if (b == '0) begin
              dz    <= 1'b1;
              state <= MD_DONE;
            end else begin
              op     <= OP_DIV;
              acc    <= '0;
              q      <= abs_a;
              q_m1   <= 1'b0;
              mcand  <= {1'b0, abs_b};
              sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
              sign_r <= a[WIDTH-1];
              cnt    <= CNT_W'(WIDTH);
              state  <= MD_RUN;
            end
          end
        end
        MD_RUN: begin
          if (op == OP_MUL) begin
            acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q    <= {booth_sum[0], q[WIDTH-1:1]};
            q_m1 <= q[0];
          end else begin
            acc <= rem_next;
            q   <= quo_next;
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= MD_FIX;
        end
        MD_FIX: begin
          if (op == OP_MUL) begin
            result_hi <= acc[WIDTH-1:0];
            result_lo <= q;
          end else begin
            result_hi <= sign_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            result_lo <= sign_q ? -q : q;
          end
          state <= MD_DONE;
        end
        MD_DONE: begin
          dz    <= 1'b0;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy     = (state == MD_RUN) || (state == MD_FIX);
  assign done     = (state == MD_DONE);
  assign div_zero = dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench: directed vector table, random ops against an
// arithmetic reference model, and hand sequences for busy-ignore and reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .result_hi  (result_hi),
    .result_lo  (result_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic; SV division truncates toward zero
  // and % takes the dividend's sign, exactly the required semantics.
  task automatic model(input bit is_div, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    longint sa, sb, p, qq, rr;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    hi = model_hi;
    lo = model_lo;
    dz = 1'b0;
    if (!is_div) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (bv == 32'd0) begin
      dz = 1'b1;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      hi = rr[31:0];
      lo = qq[31:0];
    end
  endtask

  // Operands are scrambled right after the start cycle; a start is issued during DONE
  // and must be ignored. poke>0 pulses start_div (b=0) at that cycle of the run.
  task automatic run_op(input bit is_div, input logic [31:0] av, input logic [31:0] bv,
                        input int poke, output logic [31:0] hi, output logic [31:0] lo,
                        output bit dz, output int lat, output int bcnt, output bit tmo);
    @(negedge clk);
    a = av; b = bv;
    start_mult = !is_div;
    start_div  = is_div;
    @(negedge clk);
    start_mult = 1'b0; start_div = 1'b0;
    a = $urandom; b = $urandom;
    lat = 1; bcnt = 0; tmo = 1'b0;
    while (!done) begin
      if (lat >= 60) begin
        tmo = 1'b1;
        break;
      end
      if (busy) bcnt++;
      if (lat == poke) begin
        start_div = 1'b1;
        b = '0;
      end else begin
        start_div = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start_div = 1'b0;
    hi = result_hi; lo = result_lo; dz = div_zero;
    start_mult = 1'b1; a = $urandom; b = $urandom;
    @(negedge clk);
    start_mult = 1'b0;
    chk("done_one_cycle_start_ignored", {61'd0, done, div_zero, busy}, 64'd0);
  endtask

  task automatic do_op(input string tag, input bit is_div, input logic [31:0] av,
                       input logic [31:0] bv, input int poke, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input bit exp_dz);
    logic [31:0] hi, lo;
    bit dz, tmo;
    int lat, bcnt;
    run_op(is_div, av, bv, poke, hi, lo, dz, lat, bcnt, tmo);
    chk($sformatf("%s_timeout", tag), 64'(tmo), 64'd0);
    chk($sformatf("%s_hi a=%h b=%h", tag, av, bv), 64'(hi), 64'(exp_hi));
    chk($sformatf("%s_lo a=%h b=%h", tag, av, bv), 64'(lo), 64'(exp_lo));
    chk($sformatf("%s_div_zero", tag), 64'(dz), 64'(exp_dz));
    chk($sformatf("%s_latency", tag), 64'(lat), exp_dz ? 64'd1 : 64'd34);
    chk($sformatf("%s_busy_cycles", tag), 64'(bcnt), exp_dz ? 64'd0 : 64'd33);
    $display("op %s div=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d", tag, is_div, av, bv,
             hi, lo, dz, lat);
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    logic [31:0] eh, el, ra, rb;
    bit ed, seen;
    int sel;

    vecs[0] = '{1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[2] = '{1'b1, 32'hFFFFFFF9, 32'd2,         32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[4] = '{1'b1, 32'd5,         32'd0,         32'h00000001, 32'hFFFFFFFD, 1'b1};
    vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_state", {29'd0, busy, done, div_zero, result_hi, result_lo}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      do_op($sformatf("vec%0d", i), vecs[i].is_div, vecs[i].a, vecs[i].b, 0,
            vecs[i].hi, vecs[i].lo, vecs[i].dz);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      ra  = (sel == 1) ? 32'h80000000 : $urandom;
      case (sel)
        0:       rb = 32'd0;
        2:       rb = $urandom_range(1, 9);
        3:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      model(i[0], ra, rb, eh, el, ed);
      do_op($sformatf("rnd%0d", i), i[0], ra, rb, 0, eh, el, ed);
    end

    // start_div pulsed mid-run must not disturb the multiply
    do_op("poke_run", 1'b0, 32'd1000, 32'd3, 5, 32'd0, 32'd3000, 1'b0);

    // asynchronous reset during RUN clears everything with no done pulse
    @(negedge clk);
    a = 32'd9; b = 32'd9; start_mult = 1'b1;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_reset_clear", {29'd0, busy, done, div_zero, result_hi, result_lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("no_done_after_reset", 64'(seen), 64'd0);
    model_hi = '0;
    model_lo = '0;

    do_op("after_reset", 1'b0, 32'd3, 32'd4, 0, 32'd0, 32'd12, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
